// File: rtl/sprite_pixel_fetch.sv
// Sprite pixel fetch: bounding-box hit test, sprite ROM addressing, animation frame sequencing
// and a hit pipeline aligned to ROM latency, producing a palette index plus valid flag.
module sprite_pixel_fetch #(
  parameter int unsigned SPR_W      = 32,
  parameter int unsigned SPR_H      = 32,
  parameter int unsigned FRAMES     = 4,
  parameter int unsigned ROM_LAT    = 1,
  parameter int unsigned FRAME_DIV  = 8,
  parameter logic [5:0]  TRANSP_IDX = 6'd0,
  parameter int unsigned AW         = $clog2(SPR_W * SPR_H * FRAMES),
  localparam int unsigned FW        = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
  input  logic          vga_clk,
  input  logic          reset_n,
  input  logic [9:0]    drawx,
  input  logic [9:0]    drawy,
  input  logic          de,
  input  logic          vsync_n,
  input  logic [9:0]    spr_x,
  input  logic [9:0]    spr_y,
  input  logic          flip_h,
  input  logic          anim_en,
  output logic [AW-1:0] rom_addr,
  input  logic [5:0]    rom_data,
  output logic [5:0]    pix_index,
  output logic          pix_valid,
  output logic [FW-1:0] frame
);

  localparam int unsigned CW = $clog2(SPR_W);
  localparam int unsigned RW = $clog2(SPR_H);
  localparam int unsigned DW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  logic          vsync_prev_q;
  logic          boundary;
  logic [9:0]    sx_q, sy_q;
  logic          flip_q;
  logic [DW-1:0] div_q;
  logic [FW-1:0] frame_q;

  logic          hit;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [AW-1:0] addr_d;

  logic [AW-1:0] rom_addr_q;
  logic [ROM_LAT:0] hit_q;
  logic [5:0]    pix_index_q;
  logic          pix_valid_q;

  assign boundary = vsync_prev_q & ~vsync_n;

  always_comb begin
    hit = 1'b0;
    col = '0;
    row = '0;
    addr_d = '0;
    // 11-bit compare so a box near column/row 1023 never wraps back to 0.
    hit = de
          && ({1'b0, drawx} >= {1'b0, sx_q})
          && ({1'b0, drawx} < ({1'b0, sx_q} + 11'(SPR_W)))
          && ({1'b0, drawy} >= {1'b0, sy_q})
          && ({1'b0, drawy} < ({1'b0, sy_q} + 11'(SPR_H)));
    col = drawx[CW-1:0] - sx_q[CW-1:0];
    if (flip_q) col = ~col;
    row = drawy[RW-1:0] - sy_q[RW-1:0];
    addr_d = (AW'(frame_q) << (CW + RW)) | (AW'(row) << CW) | AW'(col);
  end

  // Position, mirror and animation state change only at the vsync falling edge.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      vsync_prev_q <= 1'b1;
      sx_q         <= '0;
      sy_q         <= '0;
      flip_q       <= 1'b0;
      div_q        <= '0;
      frame_q      <= '0;
    end else begin
      vsync_prev_q <= vsync_n;
      if (boundary) begin
        sx_q   <= spr_x;
        sy_q   <= spr_y;
        flip_q <= flip_h;
        if (anim_en) begin
          if (div_q == DW'(FRAME_DIV - 1)) begin
            div_q   <= '0;
            frame_q <= (frame_q == FW'(FRAMES - 1)) ? '0 : frame_q + 1'b1;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
      end
    end
  end

  // hit_q[ROM_LAT] lines up with rom_data for the address issued ROM_LAT cycles earlier.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_addr_q  <= '0;
      hit_q       <= '0;
      pix_index_q <= '0;
      pix_valid_q <= 1'b0;
    end else begin
      if (hit) rom_addr_q <= addr_d;
      if (ROM_LAT > 0) hit_q <= {hit_q[ROM_LAT-1:0], hit};
      else hit_q <= hit;
      if (hit_q[ROM_LAT] && (rom_data != TRANSP_IDX)) begin
        pix_valid_q <= 1'b1;
        pix_index_q <= rom_data;
      end else begin
        pix_valid_q <= 1'b0;
        pix_index_q <= '0;
      end
    end
  end

  assign rom_addr  = rom_addr_q;
  assign pix_index = pix_index_q;
  assign pix_valid = pix_valid_q;
  assign frame     = frame_q;

endmodule

// File: tb/tb_sprite_pixel_fetch.sv
// Directed bench for sprite_pixel_fetch: vector table for hit/address/output cases plus
// hand-written sequences for latency, animation, mid-frame position changes and reset.
module tb_sprite_pixel_fetch;

  logic        vga_clk = 1'b0;
  logic        reset_n;
  logic [9:0]  drawx, drawy, spr_x, spr_y;
  logic        de, vsync_n, flip_h, anim_en;
  logic [11:0] rom_addr;
  logic [5:0]  rom_data, rom_val, pix_index;
  logic        pix_valid;
  logic [1:0]  frame;

  int checks = 0;
  int errors = 0;

  sprite_pixel_fetch dut (
    .vga_clk   (vga_clk),
    .reset_n   (reset_n),
    .drawx     (drawx),
    .drawy     (drawy),
    .de        (de),
    .vsync_n   (vsync_n),
    .spr_x     (spr_x),
    .spr_y     (spr_y),
    .flip_h    (flip_h),
    .anim_en   (anim_en),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .pix_index (pix_index),
    .pix_valid (pix_valid),
    .frame     (frame)
  );

  always #5 vga_clk = ~vga_clk;

  // One-cycle ROM returning a bench-chosen value.
  always @(posedge vga_clk) rom_data <= rom_val;

  typedef struct {
    logic [9:0]  sx, sy;
    logic        flip;
    logic [9:0]  x, y;
    logic        de;
    logic [5:0]  rom;
    logic [11:0] addr;
    logic [5:0]  idx;
    logic        v;
  } vec_t;

  vec_t vq[$];

  task automatic add(input int sx, input int sy, input int flip, input int x, input int y,
                     input int d, input int rom, input int addr, input int idx, input int v);
    vec_t t;
    t.sx = 10'(sx); t.sy = 10'(sy); t.flip = 1'(flip); t.x = 10'(x); t.y = 10'(y);
    t.de = 1'(d); t.rom = 6'(rom); t.addr = 12'(addr); t.idx = 6'(idx); t.v = 1'(v);
    vq.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge vga_clk);
      #1;
    end
  endtask

  task automatic vsync_pulse();
    de = 1'b0;
    vsync_n = 1'b0;
    tick();
    vsync_n = 1'b1;
    tick();
  endtask

  task automatic apply(input int x, input int y, input int d);
    drawx = 10'(x); drawy = 10'(y); de = 1'(d);
    tick(3);
  endtask

  initial begin
    reset_n = 1'b0; drawx = '0; drawy = '0; de = 1'b0; vsync_n = 1'b1;
    spr_x = '0; spr_y = '0; flip_h = 1'b0; anim_en = 1'b1; rom_val = 6'd5;

    // Reset state, including a vsync edge while reset is held.
    tick(2);
    chk("rst_addr", rom_addr, 0);
    chk("rst_idx", pix_index, 0);
    chk("rst_valid", pix_valid, 0);
    vsync_pulse();
    chk("rst_frame_vsync", frame, 0);
    reset_n = 1'b1;
    anim_en = 1'b0;
    tick();

    add(100, 50, 0, 100, 50, 1, 5,    0, 5, 1);
    add(100, 50, 0, 131, 81, 1, 5, 1023, 5, 1);
    add(100, 50, 0, 132, 50, 1, 5, 1023, 0, 0);
    add(100, 50, 0,  99, 50, 1, 5, 1023, 0, 0);
    add(100, 50, 0, 100, 82, 1, 5, 1023, 0, 0);
    add(100, 50, 0, 115, 60, 1, 9,  335, 9, 1);
    add(100, 50, 0, 100, 50, 1, 0,    0, 0, 0);
    add(100, 50, 0, 115, 60, 0, 5,    0, 0, 0);
    add(100, 50, 1, 100, 50, 1, 5,   31, 5, 1);
    add(100, 50, 1, 131, 50, 1, 5,    0, 5, 1);
    add(100, 50, 1, 110, 51, 1, 7,   53, 7, 1);
    add(630, 50, 0, 639, 50, 1, 5,    9, 5, 1);
    add(630, 50, 0, 645, 50, 0, 5,    9, 0, 0);
    add(1000, 50, 0,  5, 50, 1, 5,    9, 0, 0);
    add(1023,  0, 0, 799, 0, 1, 5,    9, 0, 0);
    add(0,     0, 0,   0, 0, 1, 3,    0, 3, 1);

    foreach (vq[i]) begin
      spr_x = vq[i].sx; spr_y = vq[i].sy; flip_h = vq[i].flip;
      vsync_pulse();
      rom_val = vq[i].rom;
      apply(vq[i].x, vq[i].y, vq[i].de);
      chk($sformatf("vec%0d_addr", i), rom_addr, vq[i].addr);
      chk($sformatf("vec%0d_idx", i), pix_index, vq[i].idx);
      chk($sformatf("vec%0d_valid", i), pix_valid, vq[i].v);
    end

    // Single-cycle hit: address after 1 cycle, pixel exactly 3 cycles after sampling.
    spr_x = 10'd100; spr_y = 10'd50; flip_h = 1'b0; rom_val = 6'd5;
    vsync_pulse();
    apply(131, 81, 1);
    de = 1'b0;
    tick(3);
    drawx = 10'd100; drawy = 10'd50; de = 1'b1;
    tick();
    chk("lat_addr_c1", rom_addr, 0);
    chk("lat_valid_c1", pix_valid, 0);
    de = 1'b0;
    tick();
    chk("lat_valid_c2", pix_valid, 0);
    tick();
    chk("lat_valid_c3", pix_valid, 1);
    chk("lat_idx_c3", pix_index, 5);
    tick();
    chk("lat_valid_c4", pix_valid, 0);

    // Animation divider and frame wrap.
    anim_en = 1'b1;
    for (int i = 0; i < 7; i++) vsync_pulse();
    chk("anim_7_frame", frame, 0);
    vsync_pulse();
    chk("anim_8_frame", frame, 1);
    apply(100, 50, 1);
    chk("anim_f1_addr", rom_addr, 1024);
    for (int i = 0; i < 24; i++) vsync_pulse();
    chk("anim_32_frame", frame, 0);
    for (int i = 0; i < 3; i++) vsync_pulse();
    anim_en = 1'b0;
    for (int i = 0; i < 20; i++) vsync_pulse();
    chk("anim_hold_frame", frame, 0);
    anim_en = 1'b1;
    for (int i = 0; i < 4; i++) vsync_pulse();
    chk("anim_div_kept", frame, 0);
    vsync_pulse();
    chk("anim_div_wrap", frame, 1);
    anim_en = 1'b0;

    // Mid-frame position change takes effect only at the next boundary.
    spr_x = 10'd200;
    apply(100, 50, 1);
    chk("mid_old_valid", pix_valid, 1);
    chk("mid_old_addr", rom_addr, 1024);
    apply(200, 50, 1);
    chk("mid_new_before", pix_valid, 0);
    vsync_pulse();
    apply(100, 50, 1);
    chk("mid_old_after", pix_valid, 0);
    apply(200, 50, 1);
    chk("mid_new_after", pix_valid, 1);
    chk("mid_new_addr", rom_addr, 1024);

    // Asynchronous reset mid-line, then no pixel until a boundary reloads the position.
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", pix_valid, 0);
    chk("arst_idx", pix_index, 0);
    chk("arst_addr", rom_addr, 0);
    chk("arst_frame", frame, 0);
    tick(2);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("post_rst_valid%0d", i), pix_valid, 0);
    end
    vsync_pulse();
    apply(200, 50, 1);
    chk("post_rst_reload", pix_valid, 1);
    chk("post_rst_addr", rom_addr, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
